fetch_queue: RTL and testbench

Instruction fetch queue on the producer side of the decode stage's instruction input. It issues one sequential fetch request at a time to the instruction cache and buffers returned words, with their PCs, in a small FIFO. It presents the FIFO head to decode and pops it whenever decode advances. On FLUSH it redirects fetch to a new target and discards every buffered or in-flight instruction.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one sequential fetch at a time to the I-cache and buffers
// returned {pc, word} pairs in a small FIFO that feeds decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_ADDR,
  input  logic        STALL_ENABLE,
  output logic        CACHE_REQ,
  output logic [31:0] CACHE_ADDR,
  input  logic        INS_CACHE_READY,
  input  logic [31:0] CACHE_DATA,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic        INS_VALID
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     cache_addr_q, cache_addr_d;
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_word_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_next;

  logic resp, push, pop, room, not_empty;

  assign CACHE_REQ  = (state_q == StWait) || (state_q == StDiscard);
  assign CACHE_ADDR = cache_addr_q;

  assign resp       = CACHE_REQ && INS_CACHE_READY;
  assign not_empty  = (count_q != '0);
  assign pop        = STALL_ENABLE && not_empty && !FLUSH;
  assign push       = resp && (state_q == StWait) && !FLUSH;
  // Occupancy after this cycle's push/pop; a new request only issues if that leaves a free slot.
  assign count_next = count_q + CntW'(push) - CntW'(pop);
  assign room       = (count_next < DepthCnt);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    cache_addr_d = cache_addr_q;
    unique case (state_q)
      StIdle: begin
        if (FLUSH) begin
          state_d      = StWait;
          cache_addr_d = FLUSH_ADDR;
          fetch_pc_d   = FLUSH_ADDR + 32'd4;
        end else if (room) begin
          state_d      = StWait;
          cache_addr_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
        end
      end
      StWait: begin
        if (!resp) begin
          // The old request stays on the bus; its response must be swallowed.
          if (FLUSH) begin
            state_d    = StDiscard;
            fetch_pc_d = FLUSH_ADDR;
          end
        end else if (FLUSH) begin
          state_d      = StWait;
          cache_addr_d = FLUSH_ADDR;
          fetch_pc_d   = FLUSH_ADDR + 32'd4;
        end else if (room) begin
          state_d      = StWait;
          cache_addr_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
        end else begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (resp) begin
          if (FLUSH) begin
            state_d      = StWait;
            cache_addr_d = FLUSH_ADDR;
            fetch_pc_d   = FLUSH_ADDR + 32'd4;
          end else begin
            state_d = StIdle;
          end
        end else if (FLUSH) begin
          fetch_pc_d = FLUSH_ADDR;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      fetch_pc_q   <= PC_RESET;
      cache_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      cache_addr_q <= cache_addr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (FLUSH) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      wr_ptr_q <= wr_ptr_q + PtrW'(push);
      count_q  <= count_next;
    end
  end

  // Storage needs no reset: the head is masked by not_empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= cache_addr_q;
      fifo_word_q[wr_ptr_q] <= CACHE_DATA;
    end
  end

  assign INS_VALID   = not_empty;
  assign INSTRUCTION = not_empty ? fifo_word_q[rd_ptr_q] : NOP;
  assign PC_OUT      = not_empty ? fifo_pc_q[rd_ptr_q] : 32'h0;

  count_bound_a : assert property (@(posedge CLK) disable iff (RST) count_q <= DepthCnt);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, backpressure, flush cases, address wrap, async reset.
module tb_fetch_queue;

  localparam logic [31:0] Key = 32'h5A5A_0000;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        stall_en = 1'b1;
  logic        rdy = 1'b1;

  logic        cache_req, ins_valid;
  logic [31:0] cache_addr, cache_data, instruction, pc_out;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_data, w_ins, w_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Cache returns a word derived from the requested address so words are traceable.
  assign cache_data = cache_addr ^ Key;
  assign w_data     = w_addr ^ Key;

  fetch_queue dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .FLUSH_ADDR(flush_addr), .STALL_ENABLE(stall_en),
    .CACHE_REQ(cache_req), .CACHE_ADDR(cache_addr), .INS_CACHE_READY(rdy),
    .CACHE_DATA(cache_data), .INSTRUCTION(instruction), .PC_OUT(pc_out), .INS_VALID(ins_valid)
  );

  fetch_queue #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .RST(rst), .FLUSH(flush), .FLUSH_ADDR(flush_addr), .STALL_ENABLE(stall_en),
    .CACHE_REQ(w_req), .CACHE_ADDR(w_addr), .INS_CACHE_READY(rdy),
    .CACHE_DATA(w_data), .INSTRUCTION(w_ins), .PC_OUT(w_pc), .INS_VALID(w_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic stall);
    rst = 1'b1; flush = 1'b0; rdy = 1'b1; stall_en = stall;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL reset req: got %b want 0", cache_req); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL reset addr: got %h want 0", cache_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", ins_valid); end
    checks++; if (instruction !== Nop) begin errors++; $display("FAIL reset ins: got %h want %h", instruction, Nop); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset pc: got %h want 0", pc_out); end
    rst = 1'b0;
    step();
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", cache_req); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", cache_addr); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (cache_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream addr[%0d]: got %h want %h", k, cache_addr, 32'(4 * k)); end
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stream valid[%0d]: got %b want 1", k, ins_valid); end
      checks++; if (pc_out !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream pc[%0d]: got %h want %h", k, pc_out, 32'(4 * (k - 1))); end
      checks++; if (instruction !== (32'(4 * (k - 1)) ^ Key)) begin errors++; $display("FAIL stream ins[%0d]: got %h want %h", k, instruction, 32'(4 * (k - 1)) ^ Key); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) step();
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL bp req_dropped: got %b want 0", cache_req); end
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL bp valid: got %b want 1", ins_valid); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL bp head_pc: got %h want 0", pc_out); end
    checks++; if (instruction !== Key) begin errors++; $display("FAIL bp head_ins: got %h want %h", instruction, Key); end
    stall_en = 1'b1;
    step();
    checks++; if (cache_addr !== 32'h10) begin errors++; $display("FAIL bp resume_addr: got %h want 10", cache_addr); end
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL bp drain_pc[1]: got %h want 4", pc_out); end
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL bp drain_valid[%0d]: got %b want 1", k, ins_valid); end
      checks++; if (pc_out !== 32'(4 * k)) begin errors++; $display("FAIL bp drain_pc[%0d]: got %h want %h", k, pc_out, 32'(4 * k)); end
    end
  endtask

  task automatic test_flush_full();
    apply_reset(1'b0);
    for (int i = 0; i < 6; i++) step();
    flush = 1'b1; flush_addr = 32'h200;
    step();
    flush = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL ff valid: got %b want 0", ins_valid); end
    checks++; if (instruction !== Nop) begin errors++; $display("FAIL ff ins: got %h want %h", instruction, Nop); end
    checks++; if (cache_addr !== 32'h200) begin errors++; $display("FAIL ff addr: got %h want 200", cache_addr); end
    step();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL ff first_valid: got %b want 1", ins_valid); end
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL ff first_pc: got %h want 200", pc_out); end
    checks++; if (instruction !== (32'h200 ^ Key)) begin errors++; $display("FAIL ff first_ins: got %h want %h", instruction, 32'h200 ^ Key); end
  endtask

  task automatic test_flush_inflight();
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) step();
    checks++; if (cache_addr !== 32'h10) begin errors++; $display("FAIL fi pending_addr: got %h want 10", cache_addr); end
    rdy = 1'b0; flush = 1'b1; flush_addr = 32'h80;
    step();
    flush = 1'b0;
    checks++; if (cache_addr !== 32'h10) begin errors++; $display("FAIL fi held_addr: got %h want 10", cache_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL fi valid_a: got %b want 0", ins_valid); end
    step();
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL fi req_held: got %b want 1", cache_req); end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL fi idle_req: got %b want 0", cache_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL fi valid_b: got %b want 0", ins_valid); end
    step();
    checks++; if (cache_addr !== 32'h80) begin errors++; $display("FAIL fi redirect_addr: got %h want 80", cache_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL fi valid_c: got %b want 0", ins_valid); end
    rdy = 1'b1;
    step();
    checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL fi first_pc: got %h want 80", pc_out); end
    checks++; if (instruction !== (32'h80 ^ Key)) begin errors++; $display("FAIL fi first_ins: got %h want %h", instruction, 32'h80 ^ Key); end
  endtask

  task automatic test_resp_flush();
    apply_reset(1'b0);
    step(); step();
    flush = 1'b1; flush_addr = 32'h40;
    step();
    flush = 1'b0;
    checks++; if (cache_addr !== 32'h40) begin errors++; $display("FAIL rf addr: got %h want 40", cache_addr); end
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL rf req: got %b want 1", cache_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rf valid: got %b want 0", ins_valid); end
    step();
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL rf first_pc: got %h want 40", pc_out); end
    checks++; if (cache_addr !== 32'h44) begin errors++; $display("FAIL rf next_addr: got %h want 44", cache_addr); end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    step();
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap addr0: got %h want fffffff8", w_addr); end
    step();
    checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap addr1: got %h want fffffffc", w_addr); end
    step();
    checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap addr2: got %h want 0", w_addr); end
    checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap pc2: got %h want fffffffc", w_pc); end
    step();
    checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wrap pc3: got %h want 0", w_pc); end
  endtask

  task automatic test_async_reset();
    step();
    checks++; if ({cache_req, ins_valid} !== 2'b11) begin errors++; $display("FAIL ar pre_active: got %b want 11", {cache_req, ins_valid}); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL ar req: got %b want 0", cache_req); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL ar addr: got %h want 0", cache_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL ar valid: got %b want 0", ins_valid); end
    checks++; if (instruction !== Nop) begin errors++; $display("FAIL ar ins: got %h want %h", instruction, Nop); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL ar pc: got %h want 0", pc_out); end
    checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL ar wrap_req: got %b want 0", w_req); end
    step();
    rst = 1'b0;
    step();
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL ar restart_addr: got %h want 0", cache_addr); end
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL ar restart_waddr: got %h want fffffff8", w_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_inflight();
    test_resp_flush();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
